// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the M-extension unit: funct3 op codes,
// the MDU state encoding and the iteration count.
package cpu_pkg;

  localparam int XLEN     = 32;
  localparam int MDU_ITER = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter_if.sv
// EX-stage <-> multiply/divide unit handshake: the CPU (master) issues one
// op with start, the unit (slave) answers with busy/done/result.
interface mdu_iter_if;

  logic                      start;
  logic                      kill;
  logic [2:0]                funct3;
  logic [cpu_pkg::XLEN-1:0]  opA;
  logic [cpu_pkg::XLEN-1:0]  opB;
  logic                      busy;
  logic                      done;
  logic [cpu_pkg::XLEN-1:0]  result;

  modport master (
    output start, kill, funct3, opA, opB,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, funct3, opA, opB,
    output busy, done, result
  );

endinterface

// File: rtl/mdu_negate.sv
// Conditional two's-complement: passes i_val through, or returns -i_val
// when i_neg is set.
module mdu_negate #(
  parameter int W = 64
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M unit: 32-step shift-add multiply / restoring divide with
// divide-by-zero and signed-overflow fast paths. busy stalls EX while running.
module mdu_iter
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         RST,
  mdu_iter_if.slave    bus
);

  mdu_state_t        r_state;
  logic [4:0]        r_cnt;
  logic [63:0]       r_acc;
  logic [XLEN-1:0]   r_b;
  logic [2:0]        r_f3;
  logic              r_sign;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_sa_en, w_sb_en, w_sa, w_sb, w_sign;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic              w_dz, w_ovf;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_div;
  logic [32:0]       w_op1, w_op2;
  logic [33:0]       w_sum;
  logic [63:0]       w_next;
  logic [63:0]       w_fix_in, w_fix;
  logic [XLEN-1:0]   w_res;

  assign w_accept = (r_state == IDLE) && bus.start && !bus.kill;

  assign w_sa_en = (bus.funct3 == MDU_MULH) || (bus.funct3 == MDU_MULHSU) ||
                   (bus.funct3 == MDU_DIV)  || (bus.funct3 == MDU_REM);
  assign w_sb_en = (bus.funct3 == MDU_MULH) || (bus.funct3 == MDU_DIV) ||
                   (bus.funct3 == MDU_REM);
  assign w_sa    = w_sa_en && bus.opA[XLEN-1];
  assign w_sb    = w_sb_en && bus.opB[XLEN-1];
  // Remainder takes the dividend's sign; everything else the product/quotient sign.
  assign w_sign  = (bus.funct3 == MDU_REM) ? w_sa : (w_sa ^ w_sb);

  mdu_negate #(.W(XLEN)) u_neg_a (.i_neg(w_sa), .i_val(bus.opA), .o_val(w_mag_a));
  mdu_negate #(.W(XLEN)) u_neg_b (.i_neg(w_sb), .i_val(bus.opB), .o_val(w_mag_b));

  assign w_dz       = bus.funct3[2] && (bus.opB == '0);
  assign w_ovf      = bus.funct3[2] && !bus.funct3[0] &&
                      (bus.opA == 32'h8000_0000) && (bus.opB == 32'hFFFF_FFFF);
  assign w_fast_res = w_dz ? (bus.funct3[1] ? bus.opA : '1)
                           : (bus.funct3[1] ? '0 : 32'h8000_0000);

  // One adder serves both: add multiplicand (mul) or trial-subtract divisor (div).
  assign w_div = r_f3[2];
  assign w_op1 = w_div ? r_acc[63:31] : {1'b0, r_acc[63:32]};
  assign w_op2 = w_div ? ~{1'b0, r_b} : {1'b0, r_b};
  assign w_sum = {1'b0, w_op1} + {1'b0, w_op2} + 34'(w_div);

  always_comb begin
    w_next = r_acc;
    if (w_div) begin
      if (w_sum[33]) w_next = {w_sum[31:0], r_acc[30:0], 1'b1};
      else           w_next = {r_acc[62:0], 1'b0};
    end else begin
      if (r_acc[0])  w_next = {w_sum[32:0], r_acc[31:1]};
      else           w_next = {1'b0, r_acc[63:1]};
    end
  end

  // Divide results are placed in the high word so a single 64-bit negate fixes both kinds.
  assign w_fix_in = w_div ? {(r_f3[1] ? w_next[63:32] : w_next[31:0]), 32'b0} : w_next;

  mdu_negate #(.W(64)) u_neg_res (.i_neg(r_sign), .i_val(w_fix_in), .o_val(w_fix));

  assign w_res = (r_f3 == MDU_MUL) ? w_fix[31:0] : w_fix[63:32];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_f3   <= bus.funct3;
      r_sign <= w_sign;
      r_b    <= w_mag_b;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_cnt <= '0;
            if (w_dz || w_ovf) begin
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_acc   <= {32'b0, w_mag_a};
              r_busy  <= 1'b1;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.kill) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_acc <= w_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'(MDU_ITER - 1)) begin
              r_result <= w_res;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed and random M-ops against a plain-arithmetic
// reference model, plus latency, kill, back-to-back and reset scenarios.
module tb_mdu_iter;

  logic clk;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  mdu_iter_if bus();

  mdu_iter dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir_v[14];

  function automatic logic [31:0] ref_res(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic logic is_fast(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op at the current cycle (cycle 0) and records what the DUT does.
  // Leaves time in the cycle after done, with that cycle's done/result captured.
  task automatic collect(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int first_b, output int nbusy, output int done_c,
                         output logic [31:0] res, output logic done_after,
                         output logic [31:0] res_after);
    first_b = -1; nbusy = 0; done_c = -1; res = 'x;
    bus.funct3 = f; bus.opA = a; bus.opB = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.opA = $urandom; bus.opB = $urandom; bus.funct3 = 3'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy === 1'b1) begin
        if (first_b < 0) first_b = c;
        nbusy++;
      end
      if (bus.done === 1'b1) begin
        done_c = c;
        res = bus.result;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    done_after = bus.done;
    res_after  = bus.result;
  endtask

  task automatic test_reset();
    RST = 1'b0; bus.start = 0; bus.kill = 0; bus.funct3 = 0; bus.opA = 0; bus.opB = 0;
    #3;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    repeat (2) @(posedge clk);
    #1 RST = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    int fb, nb, dc; logic [31:0] r, ra; logic da; int wdc, wnb, wfb;
    dir_v[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    dir_v[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    dir_v[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    dir_v[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
    dir_v[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    dir_v[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    dir_v[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
    dir_v[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
    dir_v[8]  = '{3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF};
    dir_v[9]  = '{3'd7, 32'd100,        32'd0,         32'd100};
    dir_v[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    dir_v[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
    dir_v[12] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
    dir_v[13] = '{3'd6, 32'h0000_DEAD,  32'd0,         32'h0000_DEAD};
    for (int i = 0; i < 14; i++) begin
      collect(dir_v[i].f, dir_v[i].a, dir_v[i].b, fb, nb, dc, r, da, ra);
      wdc = is_fast(dir_v[i].f, dir_v[i].a, dir_v[i].b) ? 1 : 33;
      wnb = (wdc == 1) ? 0 : 32;
      wfb = (wdc == 1) ? -1 : 1;
      total++; if (r !== dir_v[i].exp) begin bad++;
        $display("FAIL dir%0d_result got=%h want=%h", i, r, dir_v[i].exp); end
      total++; if (dc !== wdc) begin bad++;
        $display("FAIL dir%0d_done_cycle got=%0d want=%0d", i, dc, wdc); end
      total++; if (nb !== wnb || fb !== wfb) begin bad++;
        $display("FAIL dir%0d_busy cycles=%0d first=%0d want %0d/%0d", i, nb, fb, wnb, wfb); end
      total++; if (da !== 1'b0 || ra !== dir_v[i].exp) begin bad++;
        $display("FAIL dir%0d_after done=%b result=%h want 0/%h", i, da, ra, dir_v[i].exp); end
    end
  endtask

  task automatic test_random();
    int fb, nb, dc; logic [31:0] r, ra, a, b, e; logic [2:0] f; logic da; int wdc;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      e = ref_res(f, a, b);
      wdc = is_fast(f, a, b) ? 1 : 33;
      collect(f, a, b, fb, nb, dc, r, da, ra);
      total++; if (r !== e) begin bad++;
        $display("FAIL rnd%0d_result f=%0d a=%h b=%h got=%h want=%h", i, f, a, b, r, e); end
      total++; if (dc !== wdc || nb !== ((wdc == 1) ? 0 : 32)) begin bad++;
        $display("FAIL rnd%0d_timing f=%0d done_cycle=%0d busy_cycles=%0d want %0d", i, f, dc, nb, wdc); end
      total++; if (da !== 1'b0 || ra !== e) begin bad++;
        $display("FAIL rnd%0d_after done=%b result=%h want 0/%h", i, da, ra, e); end
    end
  endtask

  task automatic test_back_to_back();
    int fb, nb, dc; logic [31:0] r, ra; logic da;
    collect(3'd0, 32'd1234, 32'd5678, fb, nb, dc, r, da, ra);
    total++; if (dc !== 33 || r !== 32'd7006652) begin bad++;
      $display("FAIL b2b_first done_cycle=%0d result=%h want 33/%h", dc, r, 32'd7006652); end
    // Restart in cycle 34 of the first op; its done must land in cycle 67.
    collect(3'd5, 32'd1000, 32'd7, fb, nb, dc, r, da, ra);
    total++; if (dc + 34 !== 67 || r !== 32'd142) begin bad++;
      $display("FAIL b2b_second done_cycle=%0d result=%h want 67/%h", dc + 34, r, 32'd142); end
  endtask

  task automatic test_start_ignored();
    int dc; logic [31:0] e;
    e = ref_res(3'd4, 32'hFFFF_F000, 32'd12);
    bus.funct3 = 3'd4; bus.opA = 32'hFFFF_F000; bus.opB = 32'd12; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5 || c == 32) begin
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.opA = 32'd3; bus.opB = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin dc = c; break; end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    total++; if (dc !== 33 || bus.result !== e) begin bad++;
      $display("FAIL start_in_run done_cycle=%0d result=%h want 33/%h", dc, bus.result, e); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++;
      $display("FAIL start_in_run_idle busy=%b done=%b want 0/0", bus.busy, bus.done); end
  endtask

  task automatic test_kill();
    int fb, nb, dc, errs; logic [31:0] r, ra, r0; logic da;
    r0 = ref_res(3'd0, 32'd3, 32'd5);
    collect(3'd0, 32'd3, 32'd5, fb, nb, dc, r, da, ra);
    bus.funct3 = 3'd0; bus.opA = 32'd12345; bus.opB = 32'd678; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    errs = 0;
    for (int c = 1; c <= 10; c++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) errs++;
      if (c == 10) bus.kill = 1'b1;
      @(posedge clk); #1;
    end
    bus.kill = 1'b0;
    total++; if (errs !== 0) begin bad++; $display("FAIL kill_pre_busy bad_cycles=%0d want 0", errs); end
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++;
      $display("FAIL kill_c11 busy=%b done=%b want 0/0", bus.busy, bus.done); end
    total++; if (bus.result !== r0) begin bad++;
      $display("FAIL kill_result_kept got=%h want=%h", bus.result, r0); end
    bus.funct3 = 3'd5; bus.opA = 32'd1000; bus.opB = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    dc = -1; errs = 0;
    for (int c = 12; c <= 60; c++) begin
      if (bus.done === 1'b1) begin dc = c; break; end
      if (bus.result !== r0) errs++;
      @(posedge clk); #1;
    end
    total++; if (dc !== 44 || bus.result !== 32'd333) begin bad++;
      $display("FAIL kill_restart done_cycle=%0d result=%h want 44/%h", dc, bus.result, 32'd333); end
    total++; if (errs !== 0) begin bad++; $display("FAIL kill_restart_hold changed_cycles=%0d want 0", errs); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_kill_idle();
    int seen; logic [31:0] prev;
    prev = 32'd333;
    for (int k = 0; k < 2; k++) begin
      bus.funct3 = (k == 0) ? 3'd5 : 3'd0;
      bus.opA = 32'd77; bus.opB = (k == 0) ? 32'd0 : 32'd9;
      bus.start = 1'b1; bus.kill = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.kill = 1'b0;
      seen = 0;
      for (int c = 1; c <= 36; c++) begin
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen++;
        @(posedge clk); #1;
      end
      total++; if (seen !== 0 || bus.result !== prev) begin bad++;
        $display("FAIL start_kill_idle%0d active_cycles=%0d result=%h want 0/%h", k, seen, bus.result, prev); end
    end
  endtask

  task automatic test_reset_midrun();
    bus.funct3 = 3'd3; bus.opA = 32'hDEAD_BEEF; bus.opB = 32'h1234_5678; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    total++; if (bus.busy !== 1'b1 || bus.result === 32'h0) begin bad++;
      $display("FAIL reset_mid_pre busy=%b result=%h want 1/nonzero", bus.busy, bus.result); end
    #2 RST = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin bad++;
      $display("FAIL reset_mid_async busy=%b done=%b result=%h want 0/0/0", bus.busy, bus.done, bus.result); end
    @(posedge clk); #1 RST = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++;
      $display("FAIL reset_mid_after busy=%b done=%b want 0/0", bus.busy, bus.done); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_kill();
    test_start_kill_idle();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
